oai_slice_result_collector: RTL
===============================

Name: oai_slice_result_collector

Overview:
- Downstream consumer of the 41-bit result bus produced by the flattened INV/OAI222 gate slice, i.e. the C[40:0] word.
- Captures result words into a small synchronous FIFO with a valid/ready handshake.
- Counts how often an accepted word differs from the previously accepted word, for slice activity profiling.
- Decouples the purely combinational slice from the sequential consumers downstream of it.

Parameters:
- WIDTH, 41, result word width; must match the slice's C bus.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the change counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- res_in  input  WIDTH  result word from the gate slice; bits left unconnected upstream are treated as 0.
- in_valid  input  1  res_in holds a word to capture.
- in_ready  output  1  collector can accept a word.
- out_data  output  WIDTH  head-of-FIFO word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- fill  output  log2(DEPTH)+1  current occupancy.
- clr_stats  input  1  synchronous clear of the change counter.
- change_cnt  output  CNT_W  saturating count of accepted words that differ from the prior accepted word.

Behaviour:
- Reset (rst=1 at a clock edge) applies on that edge regardless of other inputs:
  - rd/wr pointers = 0, fill = 0.
  - out_valid = 0, out_data = 0.
  - in_ready = 1 from the first cycle after reset.
  - change_cnt = 0, last_word = 0.
  - FIFO contents are discarded. Reset mid-transfer drops all stored words; there is no partial completion.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (fill != DEPTH). It is combinational from registered state only; there is no path from out_ready, so a full FIFO never accepts, even when a pop happens in the same cycle.
- out_valid = (fill != 0).
- out_data = mem[rd_ptr] while out_valid, else 0.
  - Held stable while out_valid & !out_ready.
- Latency: a word pushed at edge N appears on out_data/out_valid after edge N when the FIFO was empty. This is 1 cycle and there is no fall-through in the same cycle.
- Simultaneous push and pop with 0 < fill < DEPTH: fill is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. fill is tracked separately, which disambiguates full from empty.
- Pop while empty and push while full are impossible by construction. X on in_valid while in_ready=0 must have no effect.
- Change counter:
  - On a push, if res_in != last_word, change_cnt increments and saturates at 2^CNT_W-1.
  - last_word <= res_in on every push.
  - If clr_stats and a counting push occur in the same cycle, clear wins: change_cnt = 0, and last_word still updates.
  - clr_stats does not affect the FIFO.
- No internal state machine beyond the FIFO occupancy: EMPTY (fill=0), PARTIAL, FULL (fill=DEPTH).
  - Transitions are by ±1 per cycle, or 0 on simultaneous push and pop.

Optional Feature:
- Macro: RESULT_PARITY_EN.
- When defined:
  - Each stored entry carries an extra bit, even parity over res_in computed at push.
  - Adds output out_par (1 bit) = stored parity of the head entry, 0 when empty or in reset.
  - Adds output par_err (1 bit, sticky), set when the XOR of out_data and out_par is 1 during a pop. It is cleared by rst or clr_stats.
- When undefined: no extra storage and no out_par/par_err ports. Behaviour is otherwise identical.

Test Plan:
1. Reset, then push 41'h0_0000_0001, 41'h1_0000_0000, 41'h1_0000_0000 with out_ready=0 → fill=3, in_ready=1, out_data=41'h1, change_cnt=2.
2. Push 4 words with out_ready=0 → fill=4, in_ready=0. A 5th in_valid is ignored. Then set out_ready=1 for 4 cycles → words drain in order, out_valid drops after the 4th pop, fill=0.
3. Continuous in_valid=1 and out_ready=1 with incrementing words from fill=1 → fill stays 1 and ordering is preserved across 10 pointer wraps.
4. Force change_cnt to 16'hFFFE via differing pushes, push 3 more differing words → saturates at 16'hFFFF. Assert clr_stats together with a differing push → change_cnt=0.
5. Fill with 3 words, assert rst for one edge while out_ready=1 → next cycle out_valid=0, fill=0, out_data=0, change_cnt=0.
6. RESULT_PARITY_EN: push 41'h7 → out_par=1. Corrupt stored parity via backdoor, pop → par_err=1 and stays 1 until clr_stats.

Source files
------------

// File: rtl/oai_slice_result_collector.sv
// oai_slice_result_collector
// Captures 41-bit result words from the INV/OAI222 gate slice into a small
// synchronous FIFO with a valid/ready handshake. It also counts how many
// accepted words differ from the previously accepted word.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   res_in, in_valid  upstream word and its valid flag
//   in_ready          FIFO not full; derived from registered occupancy only
//   out_data          head word; 0 while empty
//   out_valid         FIFO not empty
//   out_ready         consumer accepts out_data
//   fill              current occupancy, 0..DEPTH
//   clr_stats         synchronous clear of the change counter (and par_err)
//   change_cnt        saturating count of accepted words that differ from the prior one
//
// Optional feature (macro RESULT_PARITY_EN):
//   out_par           stored even parity of the head entry; 0 while empty
//   par_err           sticky flag; set when a popped word fails its parity check
module oai_slice_result_collector #(
    parameter int unsigned WIDTH = 41,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         res_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill,
    input  logic                     clr_stats,
`ifdef RESULT_PARITY_EN
    output logic                     out_par,
    output logic                     par_err,
`endif
    output logic [CNT_W-1:0]         change_cnt
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] fill_q;
    logic [WIDTH-1:0]  last_word;
    logic              push;
    logic              pop;

    // Handshake decode; in_ready gates push, so X on in_valid while full is harmless
    always_comb begin
        in_ready  = (fill_q != FILL_W'(DEPTH));
        out_valid = (fill_q != FILL_W'(0));
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        out_data  = out_valid ? mem[rd_ptr] : '0;
        fill      = fill_q;
    end

    // Storage array; contents are not reset, occupancy tracking hides stale entries
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= res_in;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fill_q <= fill_q + FILL_W'(1);
                2'b01:   fill_q <= fill_q - FILL_W'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Activity profiling: clear beats a counting push, last_word tracks every push
    always_ff @(posedge clk) begin
        if (rst) begin
            change_cnt <= '0;
            last_word  <= '0;
        end else begin
            if (clr_stats) begin
                change_cnt <= '0;
            end else if (push && (res_in != last_word) && (change_cnt != {CNT_W{1'b1}})) begin
                change_cnt <= change_cnt + CNT_W'(1);
            end
            if (push) last_word <= res_in;
        end
    end

`ifdef RESULT_PARITY_EN
    logic par_mem [DEPTH];

    // Parity bit alongside each entry, chosen so word plus bit has even weight
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            par_mem[wr_ptr] <= ^res_in;
        end
    end

    always_comb begin
        out_par = out_valid ? par_mem[rd_ptr] : 1'b0;
    end

    // Sticky error on a popped entry whose word and parity bit have odd weight
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            par_err <= 1'b0;
        end else if (pop && (^{out_data, out_par})) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule
